// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, derived sync windows and shared types
// for the VGA frame core and its delay line.
package vga_timing_pkg;

    typedef logic [10:0] coord_t;

    localparam int H_DISP  = 640;
    localparam int H_FRONT = 16;
    localparam int H_BACK  = 48;
    localparam int H_RETR  = 96;
    localparam int V_DISP  = 480;
    localparam int V_FRONT = 10;
    localparam int V_BACK  = 33;
    localparam int V_RETR  = 2;

    localparam int HT       = H_DISP + H_FRONT + H_BACK + H_RETR;
    localparam int VT       = V_DISP + V_FRONT + V_BACK + V_RETR;
    localparam int HS_START = H_DISP + H_FRONT;
    localparam int HS_END   = HS_START + H_RETR - 1;
    localparam int VS_START = V_DISP + V_FRONT;
    localparam int VS_END   = VS_START + V_RETR - 1;

    // Timing flags carried down the delay line; syncs are active-low.
    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// W-bit, DLY-stage clk-rate shift register with async active-low reset to INIT.
module vga_delay_line #(
    parameter int           W    = 1,
    parameter int           DLY  = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DLY-1:0][W-1:0] pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= {DLY{INIT}};
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DLY-1];

endmodule

// File: rtl/vga_sync_frame_core.sv
// Pixel-rate frame counter (x, y) for the stream cores plus the latency-matched
// sync/blanking output stage that drives the VGA pins.
module vga_sync_frame_core
    import vga_timing_pkg::*;
#(
    parameter int CD       = 12,
    parameter int HD       = H_DISP,
    parameter int HF       = H_FRONT,
    parameter int HB       = H_BACK,
    parameter int HR       = H_RETR,
    parameter int VD       = V_DISP,
    parameter int VF       = V_FRONT,
    parameter int VB       = V_BACK,
    parameter int VR       = V_RETR,
    parameter int TICK_DIV = 4,
    parameter int PIPE_DLY = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          pixel_tick,
    output logic          frame_start,
    input  logic [CD-1:0] si_rgb,
    output logic          hsync,
    output logic          vsync,
    output logic [CD-1:0] rgb
);

    localparam coord_t H_MAX = coord_t'(HD + HF + HB + HR - 1);
    localparam coord_t V_MAX = coord_t'(VD + VF + VB + VR - 1);
    localparam coord_t H_VIS = coord_t'(HD);
    localparam coord_t V_VIS = coord_t'(VD);
    localparam coord_t HS_LO = coord_t'(HD + HF);
    localparam coord_t HS_HI = coord_t'(HD + HF + HR - 1);
    localparam coord_t VS_LO = coord_t'(VD + VF);
    localparam coord_t VS_HI = coord_t'(VD + VF + VR - 1);

    localparam int          TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt, tick_nxt;
    logic          tick_flag_nxt;
    logic          fs_nxt;
    coord_t        x_nxt, y_nxt;
    sync_t         raw, dly;

    // pixel_tick and frame_start are registered from next-state values so they
    // line up with tick_cnt==TICK_DIV-1 and with the tick that wraps to 0,0.
    always_comb begin
        tick_nxt      = (tick_cnt == T_MAX) ? '0 : tick_cnt + TW'(1);
        tick_flag_nxt = (tick_nxt == T_MAX);
        x_nxt         = x;
        y_nxt         = y;
        if (pixel_tick) begin
            if (x == H_MAX) begin
                x_nxt = '0;
                y_nxt = (y == V_MAX) ? '0 : y + 11'd1;
            end else begin
                x_nxt = x + 11'd1;
            end
        end
        fs_nxt = tick_flag_nxt && (x_nxt == H_MAX) && (y_nxt == V_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            tick_cnt    <= tick_nxt;
            pixel_tick  <= tick_flag_nxt;
            frame_start <= fs_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
        end
    end

    always_comb begin
        raw.hs  = ~in_range(x, HS_LO, HS_HI);
        raw.vs  = ~in_range(y, VS_LO, VS_HI);
        raw.von = (x < H_VIS) && (y < V_VIS);
    end

    // Matches the stream pipeline latency so rgb and syncs leave together.
    vga_delay_line #(
        .W    ($bits(sync_t)),
        .DLY  (PIPE_DLY),
        .INIT (SYNC_IDLE)
    ) u_sync_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (raw),
        .q       (dly)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else begin
            hsync <= dly.hs;
            vsync <= dly.vs;
            rgb   <= dly.von ? si_rgb : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_frame_core.sv
// Random-rgb bench for vga_sync_frame_core on a shrunken timing so whole frames
// fit; expectations come from clk-count arithmetic, not from DUT state.
module tb_vga_sync_frame_core;

    localparam int CD = 12;
    localparam int HD = 16, HF = 2, HB = 3, HR = 4;
    localparam int VD = 6,  VF = 1, VB = 2, VR = 2;
    localparam int TD = 4;
    localparam int PD = 3;
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [10:0]   x, y;
    logic          pixel_tick, frame_start, hsync, vsync;
    logic [CD-1:0] si_rgb = '1;
    logic [CD-1:0] rgb;

    int n_cmp = 0;
    int n_err = 0;
    int k;
    int hs_run, vs_run, last_fs;
    logic [CD-1:0] si_hist [0:8191];

    always #5 clk = ~clk;

    vga_sync_frame_core #(
        .CD(CD), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR),
        .TICK_DIV(TD), .PIPE_DLY(PD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start),
        .si_rgb      (si_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // k clk edges after reset release have completed k/TD whole pixels.
    function automatic void model_xy(input int kk, output int mx, output int my);
        int p;
        p  = kk / TD;
        mx = p % HT;
        my = (p / HT) % VT;
    endfunction

    task automatic check_cycle();
        int mx, my, dx, dy;
        logic e_tick, e_hs, e_vs;
        logic [CD-1:0] e_rgb;
        model_xy(k, mx, my);
        e_tick = ((k % TD) == TD - 1);
        chk($sformatf("x k=%0d", k), 32'(x), mx);
        chk($sformatf("y k=%0d", k), 32'(y), my);
        chk($sformatf("pixel_tick k=%0d", k), 32'(pixel_tick), 32'(e_tick));
        chk($sformatf("frame_start k=%0d", k), 32'(frame_start),
            32'(e_tick && mx == HT - 1 && my == VT - 1));
        // Pins reflect the coordinates PD+1 clk earlier.
        if (k >= PD + 1) begin
            model_xy(k - PD - 1, dx, dy);
            e_hs  = !(dx >= HD + HF && dx < HD + HF + HR);
            e_vs  = !(dy >= VD + VF && dy < VD + VF + VR);
            e_rgb = (dx < HD && dy < VD) ? si_hist[k-1] : '0;
        end else begin
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_rgb = '0;
        end
        chk($sformatf("hsync k=%0d", k), 32'(hsync), 32'(e_hs));
        chk($sformatf("vsync k=%0d", k), 32'(vsync), 32'(e_vs));
        chk($sformatf("rgb k=%0d", k), 32'(rgb), 32'(e_rgb));

        if (!hsync) hs_run++;
        else begin
            if (hs_run > 0) chk("hsync_low_len", hs_run, HR * TD);
            hs_run = 0;
        end
        if (!vsync) vs_run++;
        else begin
            if (vs_run > 0) chk("vsync_low_len", vs_run, VR * HT * TD);
            vs_run = 0;
        end
        if (frame_start) begin
            if (last_fs >= 0) chk("frame_period", k - last_fs, HT * VT * TD);
            last_fs = k;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " x"}, 32'(x), 0);
        chk({tag, " y"}, 32'(y), 0);
        chk({tag, " pixel_tick"}, 32'(pixel_tick), 0);
        chk({tag, " frame_start"}, 32'(frame_start), 0);
        chk({tag, " hsync"}, 32'(hsync), 1);
        chk({tag, " vsync"}, 32'(vsync), 1);
        chk({tag, " rgb"}, 32'(rgb), 0);
    endtask

    // Called at a negedge with reset asserted; releases it and runs n clk.
    task automatic run_seg(input int n);
        k       = 0;
        hs_run  = 0;
        vs_run  = 0;
        last_fs = -1;
        reset_n = 1'b1;
        check_cycle();
        si_rgb     = CD'($urandom);
        si_hist[0] = si_rgb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_cycle();
            si_rgb     = CD'($urandom);
            si_hist[k] = si_rgb;
        end
    endtask

    // Assert reset between clk edges and check it takes effect without an edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        si_rgb  = '1;
        #1;
        check_reset_state({tag, " async"});
        repeat (2) @(negedge clk);
        check_reset_state({tag, " held"});
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");

        // Mid-line reset while hsync is low on line 1.
        run_seg((1 * HT + HD + HF + 2) * TD + 1);
        chk("pre_reset hsync_low", 32'(hsync), 0);
        async_reset("midline");

        // Two full frames and a bit: line/frame wraps, sync widths, frame period.
        run_seg(2 * HT * VT * TD + 200);
        async_reset("frame_end");

        // Random-length run with random reset point.
        run_seg(int'($urandom_range(300, 1500)));
        async_reset("random");

        run_seg(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
